fp16_adder_unit: RTL and testbench
==================================

# fp16_adder_unit

Multi-cycle IEEE 754 binary16 adder/subtractor (instantiated as `floating_point_adder`) for the TTPU datapath. It accepts two half-precision operands on an enable strobe and computes their sum with round-to-nearest-even. It then presents the result with a one-cycle `ready` pulse. Subtraction is performed by the caller flipping the sign bit of `b`.

## Interface
- `DATA_WIDTH`, default 16: operand and result width. Only 16 (1 sign, 5 exponent, 10 fraction, bias 15) is supported.
- `clk`  in  1: single clock, rising-edge.
- `reset`  in  1: reset, asynchronous and active-low (asserted when 0).
- `en`  in  1: start request; sampled only in IDLE.
- `a`  in  DATA_WIDTH: operand A, captured when `en` is accepted.
- `b`  in  DATA_WIDTH: operand B, captured when `en` is accepted.
- `ready`  out  1: one-cycle pulse marking a valid `result`.
- `result`  out  DATA_WIDTH: sum; holds its value until the next completion.

## Operation
- FSM states and transitions:
  - IDLE → UNPACK → ALIGN → ADD → NORM → ROUND → IDLE.
  - IDLE advances only when `en`=1; every other state advances unconditionally.
- UNPACK:
  - Register sign, exponent and mantissa of each operand; implicit 1 for normals, 0 for subnormals (subnormal effective exponent 1).
  - Classify each operand as zero, subnormal, normal, infinity or NaN.
- ALIGN:
  - Swap so that the larger magnitude is operand X.
  - Right-shift the smaller mantissa by the exponent difference, keeping guard, round and sticky bits. A shift of 14 or more leaves only sticky.
- ADD:
  - Same signs: add mantissas. Different signs: subtract (X minus Y).
  - Result sign is the sign of X.
- NORM:
  - Carry-out: shift right 1, exponent +1.
  - Otherwise shift left by the leading-zero count. Stop the shift at exponent 1, producing a subnormal.
- ROUND:
  - Round to nearest, ties to even.
  - Mantissa overflow after rounding increments the exponent.
  - Exponent of 31 or more gives infinity with the result sign.
- Special cases, evaluated in UNPACK and bypassing arithmetic:
  - Any NaN input → 16'h7E00.
  - +inf plus −inf → 16'h7E00.
  - inf plus finite → that inf.
- Signed zeros:
  - Exact zero sum → +0 (16'h0000).
  - −0 plus −0 → −0 (16'h8000).
- Flags are not produced.

## Timing
- Reset (`reset`=0, asynchronous) sets state to IDLE, `ready`=0, `result`=16'h0000, and clears all internal registers. A reset mid-operation aborts it, and no `ready` is produced.
- `en`=1 at rising edge k in IDLE captures `a`/`b`.
- `ready`=1 and the new `result` appear after edge k+5, for exactly one cycle. Latency is fixed at 5 cycles regardless of data.
- `en` and operand changes are ignored outside IDLE.
- If `en` is still high when the FSM returns to IDLE, a new operation starts on that edge, giving back-to-back throughput of one result per 6 cycles.
- `result` changes only on the edge that raises `ready`.

## Structure
- Package `fp16_pkg` holds:
  - Field widths: EXP_W=5, FRAC_W=10, BIAS=15.
  - Constants: QNAN=16'h7E00, POS_INF=16'h7C00, NEG_INF=16'hFC00.
  - The FSM state enum.
- Sub-module `fp16_lzc`: combinational leading-zero counter over the 14-bit working mantissa, used by NORM.

## Test plan
- Cancellation: reset pulse, then `a`=16'h3C00, `b`=16'hBC00 with `en`=1 → `ready` 5 cycles later, `result`=16'h0000.
- Basic add and subtract:
  - 3C00 + 3C00 → 4000.
  - 3C00 + C200 → C000 (1 − 3 = −2).
  - Check `ready` is a single-cycle pulse.
- Rounding:
  - 3C00 + 1400 → 3C01.
  - 3C00 + 1000 (tie) → 3C00, ties to even.
  - 3C01 + 1000 → 3C02.
- Overflow and specials:
  - 7BFF + 7BFF → 7C00.
  - 7C00 + FC00 → 7E00.
  - 7E01 + 3C00 → 7E00.
  - FC00 + 3C00 → FC00.
- Subnormals and zeros:
  - 0001 + 0001 → 0002.
  - 03FF + 0001 → 0400.
  - 8000 + 8000 → 8000.
- Control:
  - Assert reset during ALIGN → no `ready`, `result`=0000.
  - Hold `en` high → one result every 6 cycles.
  - Operand changes mid-operation do not affect the result.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared binary16 field widths, special encodings, FSM states and the
// unpacked-operand record used across the adder datapath.
package fp16_pkg;
  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int BIAS   = 15;
  localparam int MAN_W  = FRAC_W + 1;  // with implicit bit
  localparam int WRK_W  = MAN_W + 3;   // mantissa + guard, round, sticky
  localparam int LZ_W   = $clog2(WRK_W + 1);

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;
  localparam logic [15:0] NEG_INF = 16'hFC00;

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND
  } state_t;

  // Exponent carries two headroom bits so rounding overflow never wraps.
  typedef struct packed {
    logic             s;
    logic [6:0]       e;
    logic [MAN_W-1:0] m;
  } unp_t;

  // Subnormals get effective exponent 1 and no implicit bit.
  function automatic unp_t unpack(input logic [15:0] v);
    unp_t u;
    u.s = v[15];
    u.e = (v[14:10] == '0) ? 7'd1 : {2'b00, v[14:10]};
    u.m = {|v[14:10], v[9:0]};
    return u;
  endfunction
endpackage

// File: rtl/fp16_lzc.sv
// Leading-zero counter over the working mantissa; all-zero input yields W.
module fp16_lzc
  import fp16_pkg::*;
#(
  parameter int W = WRK_W
) (
  input  logic [W-1:0]    i_val,
  output logic [LZ_W-1:0] o_cnt
);
  always_comb begin
    o_cnt = LZ_W'(W);
    for (int i = 0; i < W; i++)
      if (i_val[i]) o_cnt = LZ_W'(W - 1 - i);
  end
endmodule

// File: rtl/fp16_adder_unit.sv
// Multi-cycle binary16 adder: one operation walks UNPACK..ROUND, result is
// registered on the ROUND exit edge together with a one-cycle ready pulse.
module fp16_adder_unit
  import fp16_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] result
);
  state_t           r_state, w_state_nxt;
  logic [15:0]      r_a, r_b;
  unp_t             r_ua, r_ub;
  logic             r_spec;
  logic [15:0]      r_spec_val;
  logic             r_xs, r_sub;
  logic [6:0]       r_xe, r_ne;
  logic [WRK_W-1:0] r_xm, r_ym, r_nm;
  logic [WRK_W:0]   r_sum;

  // Special operands resolve here and bypass the arithmetic result.
  logic w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_spec;
  logic [15:0] w_spec_val;
  assign w_a_nan = (&r_a[14:10]) &  (|r_a[9:0]);
  assign w_b_nan = (&r_b[14:10]) &  (|r_b[9:0]);
  assign w_a_inf = (&r_a[14:10]) & ~(|r_a[9:0]);
  assign w_b_inf = (&r_b[14:10]) & ~(|r_b[9:0]);

  always_comb begin
    w_spec     = 1'b1;
    w_spec_val = QNAN;
    if (w_a_nan || w_b_nan)                           w_spec_val = QNAN;
    else if (w_a_inf && w_b_inf && (r_a[15] != r_b[15])) w_spec_val = QNAN;
    else if (w_a_inf)                                 w_spec_val = r_a;
    else if (w_b_inf)                                 w_spec_val = r_b;
    else if (r_a == 16'h8000 && r_b == 16'h8000)      w_spec_val = 16'h8000;
    else                                              w_spec = 1'b0;
  end

  // Align: X is the larger magnitude; Y shifted right with sticky collapse.
  unp_t                 w_x, w_y;
  logic                 w_swap;
  logic [6:0]           w_d;
  logic [WRK_W-1:0]     w_yext, w_yal;
  logic [2*WRK_W-1:0]   w_ysh;
  assign w_swap = {r_ub.e, r_ub.m} > {r_ua.e, r_ua.m};
  assign w_x    = w_swap ? r_ub : r_ua;
  assign w_y    = w_swap ? r_ua : r_ub;
  assign w_d    = w_x.e - w_y.e;
  assign w_yext = {w_y.m, 3'b000};
  assign w_ysh  = {w_yext, {WRK_W{1'b0}}} >> w_d[3:0];
  assign w_yal  = (w_d >= 7'(WRK_W)) ? {{(WRK_W-1){1'b0}}, |w_y.m}
                : (w_ysh[2*WRK_W-1:WRK_W] | {{(WRK_W-1){1'b0}}, |w_ysh[WRK_W-1:0]});

  // Normalize: left shift capped so the exponent never drops below 1.
  logic [LZ_W-1:0]  w_lz;
  logic [6:0]       w_lim, w_sh, w_ne;
  logic [WRK_W-1:0] w_nm;
  fp16_lzc #(.W(WRK_W)) u_lzc (.i_val(r_sum[WRK_W-1:0]), .o_cnt(w_lz));
  assign w_lim = r_xe - 7'd1;
  assign w_sh  = (7'(w_lz) > w_lim) ? w_lim : 7'(w_lz);

  always_comb begin
    w_nm = r_sum[WRK_W-1:0] << w_sh;
    w_ne = r_xe - w_sh;
    if (r_sum[WRK_W]) begin
      w_nm = r_sum[WRK_W:1] | {{(WRK_W-1){1'b0}}, r_sum[0]};
      w_ne = r_xe + 7'd1;
    end
  end

  // Round to nearest even on guard / round|sticky / lsb.
  logic             w_rup;
  logic [MAN_W:0]   w_mr;
  logic [MAN_W-1:0] w_mf;
  logic [6:0]       w_ef;
  logic [15:0]      w_res;
  assign w_rup = r_nm[2] & (r_nm[1] | r_nm[0] | r_nm[3]);
  assign w_mr  = {1'b0, r_nm[WRK_W-1:3]} + (MAN_W+1)'(w_rup);
  assign w_mf  = w_mr[MAN_W] ? w_mr[MAN_W:1] : w_mr[MAN_W-1:0];
  assign w_ef  = w_mr[MAN_W] ? r_ne + 7'd1 : r_ne;

  always_comb begin
    w_res = {r_xs, (w_mf[FRAC_W] ? w_ef[EXP_W-1:0] : 5'd0), w_mf[FRAC_W-1:0]};
    if (r_spec)             w_res = r_spec_val;
    else if (r_nm == '0)    w_res = 16'h0000;
    else if (w_ef >= 7'd31) w_res = r_xs ? NEG_INF : POS_INF;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (en) w_state_nxt = S_UNPACK;
      S_UNPACK: w_state_nxt = S_ALIGN;
      S_ALIGN:  w_state_nxt = S_ADD;
      S_ADD:    w_state_nxt = S_NORM;
      S_NORM:   w_state_nxt = S_ROUND;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_a <= '0;  r_b <= '0;  r_ua <= '0;  r_ub <= '0;
      r_spec <= 1'b0;  r_spec_val <= '0;
      r_xs <= 1'b0;  r_sub <= 1'b0;  r_xe <= '0;  r_xm <= '0;  r_ym <= '0;
      r_sum <= '0;  r_nm <= '0;  r_ne <= '0;
      ready <= 1'b0;  result <= '0;
    end else begin
      r_state <= w_state_nxt;
      ready   <= (r_state == S_ROUND);
      case (r_state)
        S_IDLE: if (en) begin r_a <= a; r_b <= b; end
        S_UNPACK: begin
          r_ua <= unpack(r_a);  r_ub <= unpack(r_b);
          r_spec <= w_spec;  r_spec_val <= w_spec_val;
        end
        S_ALIGN: begin
          r_xs <= w_x.s;  r_xe <= w_x.e;  r_sub <= w_x.s ^ w_y.s;
          r_xm <= {w_x.m, 3'b000};  r_ym <= w_yal;
        end
        S_ADD:  r_sum <= r_sub ? ({1'b0, r_xm} - {1'b0, r_ym}) : ({1'b0, r_xm} + {1'b0, r_ym});
        S_NORM: begin r_nm <= w_nm;  r_ne <= w_ne; end
        default: result <= w_res;
      endcase
    end
  end
endmodule

// File: tb/tb_fp16_adder_unit.sv
// Directed-vector bench for fp16_adder_unit: arithmetic, rounding, specials,
// latency/pulse shape, mid-operation reset and back-to-back throughput.
module tb_fp16_adder_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        ready;
  logic [15:0] result;
  int          checks = 0;
  int          errors = 0;

  fp16_adder_unit #(.DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .en(en), .a(a), .b(b),
    .ready(ready), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called 1 time unit after a rising edge with the FSM idle.
  task automatic op(input logic [15:0] ta, input logic [15:0] tb_v,
                    input logic [15:0] exp, input string tag);
    int lat;
    a = ta; b = tb_v; en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    lat = 0;
    while (!ready && lat < 10) begin @(posedge clk); #1; lat++; end
    check({tag, " latency"}, 32'(lat), 32'd5);
    check({tag, " result"}, {16'h0, result}, {16'h0, exp});
    @(posedge clk); #1;
    check({tag, " pulse"}, {31'h0, ready}, 32'd0);
  endtask

  initial begin
    int   lat, gap;
    logic seen;
    #12;
    check("reset ready", {31'h0, ready}, 32'd0);
    check("reset result", {16'h0, result}, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    op(16'h3C00, 16'hBC00, 16'h0000, "cancel");
    op(16'h3C00, 16'h3C00, 16'h4000, "1+1");
    op(16'h3C00, 16'hC200, 16'hC000, "1-3");
    op(16'h3C00, 16'h1400, 16'h3C01, "rnd up");
    op(16'h3C00, 16'h1000, 16'h3C00, "tie even");
    op(16'h3C01, 16'h1000, 16'h3C02, "tie odd");
    op(16'h7BFF, 16'h7BFF, 16'h7C00, "ovf");
    op(16'h7C00, 16'hFC00, 16'h7E00, "inf-inf");
    op(16'h7E01, 16'h3C00, 16'h7E00, "nan");
    op(16'hFC00, 16'h3C00, 16'hFC00, "-inf+1");
    op(16'h0001, 16'h0001, 16'h0002, "sub+sub");
    op(16'h03FF, 16'h0001, 16'h0400, "sub->norm");
    op(16'h8000, 16'h8000, 16'h8000, "-0+-0");

    // Reset asserted while the operation is in ALIGN.
    a = 16'h3C00; b = 16'h3C00; en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; #1;
    check("midrst ready", {31'h0, ready}, 32'd0);
    check("midrst result", {16'h0, result}, 32'h0);
    #2 reset = 1'b1;
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; seen |= ready; end
    check("midrst no ready", {31'h0, seen}, 32'd0);

    // Operands changed mid-operation must not leak into the result.
    a = 16'h3C00; b = 16'hC200; en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    a = 16'h7C00; b = 16'h7E00;
    lat = 0;
    while (!ready && lat < 10) begin @(posedge clk); #1; lat++; end
    check("hold latency", 32'(lat), 32'd5);
    check("hold result", {16'h0, result}, 32'h0000C000);
    @(posedge clk); #1;

    // en held high: second op captures b changed while the first ran.
    a = 16'h3C00; b = 16'h3C00; en = 1'b1;
    @(posedge clk); #1 b = 16'h4000;
    lat = 0;
    while (!ready && lat < 10) begin @(posedge clk); #1; lat++; end
    check("b2b first latency", 32'(lat), 32'd5);
    check("b2b first result", {16'h0, result}, 32'h00004000);
    gap = 0;
    do begin @(posedge clk); #1; gap++; end while (!ready && gap < 12);
    en = 1'b0;
    check("b2b gap", 32'(gap), 32'd6);
    check("b2b second result", {16'h0, result}, 32'h00004200);
    @(posedge clk); #1;
    check("b2b pulse", {31'h0, ready}, 32'd0);
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; seen |= ready; end
    check("b2b stops", {31'h0, seen}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
